reg_writeback: RTL

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback.sv | 96 +++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// Write-back stage: registers execute results toward the register group and
// tracks per-register pending writes to generate an issue stall.
module reg_writeback #(
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_PEND = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_in,
    input  logic          wb_we,
    input  logic [1:0]    wb_rd,
    input  logic [DW-1:0] wb_data,
    input  logic          iss_en,
    input  logic [1:0]    iss_rd,
    input  logic [1:0]    iss_rs,
    input  logic          iss_rdr,
    input  logic          iss_we,
    output logic          en_out,
    output logic [3:0]    reg_en,
    output logic [DW-1:0] d_in,
    output logic [3:0]    busy,
    output logic          stall,
    output logic          err
);

    localparam int unsigned NREG = 4;
    localparam int unsigned CW   = 2;

    logic [CW-1:0]   cnt     [NREG];
    logic [CW-1:0]   cnt_nxt [NREG];
    logic            en_out_nxt;
    logic [NREG-1:0] reg_en_nxt;
    logic [DW-1:0]   d_in_nxt;
    logic            err_nxt;
    logic            issue_inc;

    // Busy and stall come only from registered counters, so a retiring
    // register keeps stalling for the cycle its reg_en pulse is high.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt[r] != '0);
        end
        stall = iss_en & (busy[iss_rs]
                        | (iss_rdr & busy[iss_rd])
                        | (iss_we & (cnt[iss_rd] == CW'(MAX_PEND))));
        issue_inc = iss_en & ~stall & iss_we;
    end

    // Next-state: output pipeline register and pending-counter update.
    always_comb begin
        cnt_nxt    = cnt;
        err_nxt    = err;
        en_out_nxt = en_in;
        reg_en_nxt = '0;
        d_in_nxt   = d_in;

        if (en_in && wb_we) begin
            reg_en_nxt = NREG'(1) << wb_rd;
            d_in_nxt   = wb_data;
        end

        for (int r = 0; r < NREG; r++) begin
            if (reg_en[r] && cnt[r] == '0) begin
                err_nxt = 1'b1;
            end
            if (issue_inc && iss_rd == CW'(r)) begin
                if (!reg_en[r]) begin
                    cnt_nxt[r] = cnt[r] + CW'(1);
                end
            end else if (reg_en[r] && cnt[r] != '0) begin
                cnt_nxt[r] = cnt[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_out <= 1'b0;
            reg_en <= '0;
            d_in   <= '0;
            err    <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            en_out <= en_out_nxt;
            reg_en <= reg_en_nxt;
            d_in   <= d_in_nxt;
            err    <= err_nxt;
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

endmodule
